// File: rtl/jt5205_romfeed_if.sv
// Bundle of control, ROM and decoder-side signals for jt5205_romfeed.
//   master: drives the controls (cen_lo, start, stop, addresses) and the ROM reply
//           (rom_data, rom_ok); observes rom_addr/rom_cs, din and the status flags.
//   slave : the feeder itself, the mirror image of master.
interface jt5205_romfeed_if #(
    parameter int unsigned AW = 16
) ();
    logic          cen_lo;
    logic          start;
    logic          stop;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic [3:0]    din;
    logic          busy;
    logic          done;
    logic          underrun;

    modport master (
        output cen_lo, start, stop, start_addr, end_addr, rom_data, rom_ok,
        input  rom_addr, rom_cs, din, busy, done, underrun
    );

    modport slave (
        input  cen_lo, start, stop, start_addr, end_addr, rom_data, rom_ok,
        output rom_addr, rom_cs, din, busy, done, underrun
    );
endinterface

// File: rtl/jt5205_romfeed.sv
// Streams ADPCM nibbles from a byte-wide ROM into a 5205-style decoder.
// A two-byte buffer (cur being played, nxt prefetched) hides ROM latency; each
// cen_lo strobe registers the next nibble of cur onto din.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of jt5205_romfeed_if (controls, ROM port, din, status)
module jt5205_romfeed #(
    parameter int unsigned AW       = 16,
    parameter bit          HI_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    jt5205_romfeed_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StWait, StPlay} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] end_q, end_d;
    logic [7:0]    cur_q, cur_d, nxt_q, nxt_d;
    logic          cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
    logic          cur_last_q, cur_last_d, nxt_last_q, nxt_last_d;
    logic          phase_q, phase_d;
    logic          fetched_q, fetched_d;   // byte at end_addr already fetched
    logic          stable_q, stable_d;     // rom_addr unchanged since the previous cycle
    logic [3:0]    din_q, din_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic          rom_cs;
    logic          accept;
    logic          is_last;
    logic [3:0]    nib_first, nib_second;

    always_comb begin
        rom_cs     = (state_q != StIdle) && (!cur_v_q || !nxt_v_q) && !fetched_q;
        // rom_ok right after an address change may belong to the old address
        accept     = rom_cs && bus.rom_ok && stable_q;
        is_last    = (addr_q == end_q);
        nib_first  = HI_FIRST ? cur_q[7:4] : cur_q[3:0];
        nib_second = HI_FIRST ? cur_q[3:0] : cur_q[7:4];

        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        cur_d      = cur_q;
        cur_v_d    = cur_v_q;
        cur_last_d = cur_last_q;
        nxt_d      = nxt_q;
        nxt_v_d    = nxt_v_q;
        nxt_last_d = nxt_last_q;
        phase_d    = phase_q;
        fetched_d  = fetched_q;
        din_d      = din_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        if (bus.start) begin
            state_d    = StWait;
            addr_d     = bus.start_addr;
            end_d      = bus.end_addr;
            cur_v_d    = 1'b0;
            nxt_v_d    = 1'b0;
            phase_d    = 1'b0;
            fetched_d  = 1'b0;
            underrun_d = 1'b0;
            din_d      = 4'd0;
        end else if (bus.stop) begin
            state_d = StIdle;
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
            din_d   = 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    // the final nibble stays on din until the decoder has taken it
                    if (bus.cen_lo) din_d = 4'd0;
                end
                StWait: begin
                    if (accept) begin
                        cur_d      = bus.rom_data;
                        cur_v_d    = 1'b1;
                        cur_last_d = is_last;
                        addr_d     = addr_q + AW'(1);
                        fetched_d  = is_last;
                        state_d    = StPlay;
                    end
                end
                StPlay: begin
                    if (bus.cen_lo) begin
                        if (!cur_v_q) begin
                            din_d = 4'd0;          // starved after an underrun
                        end else if (!phase_q) begin
                            din_d   = nib_first;
                            phase_d = 1'b1;
                        end else begin
                            din_d   = nib_second;
                            phase_d = 1'b0;
                            if (cur_last_q) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                                cur_v_d = 1'b0;
                                nxt_v_d = 1'b0;
                            end else if (nxt_v_q) begin
                                cur_d      = nxt_q;
                                cur_last_d = nxt_last_q;
                                nxt_v_d    = 1'b0;
                            end else begin
                                underrun_d = 1'b1;
                                cur_v_d    = 1'b0;
                            end
                        end
                    end
                    // new byte lands in whichever slot is free after the shift
                    if (accept) begin
                        if (!cur_v_d) begin
                            cur_d      = bus.rom_data;
                            cur_v_d    = 1'b1;
                            cur_last_d = is_last;
                        end else begin
                            nxt_d      = bus.rom_data;
                            nxt_v_d    = 1'b1;
                            nxt_last_d = is_last;
                        end
                        addr_d    = addr_q + AW'(1);
                        fetched_d = is_last;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        stable_d = (addr_d == addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            end_q      <= '0;
            cur_q      <= '0;
            cur_v_q    <= 1'b0;
            cur_last_q <= 1'b0;
            nxt_q      <= '0;
            nxt_v_q    <= 1'b0;
            nxt_last_q <= 1'b0;
            phase_q    <= 1'b0;
            fetched_q  <= 1'b0;
            stable_q   <= 1'b0;
            din_q      <= 4'd0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            cur_q      <= cur_d;
            cur_v_q    <= cur_v_d;
            cur_last_q <= cur_last_d;
            nxt_q      <= nxt_d;
            nxt_v_q    <= nxt_v_d;
            nxt_last_q <= nxt_last_d;
            phase_q    <= phase_d;
            fetched_q  <= fetched_d;
            stable_q   <= stable_d;
            din_q      <= din_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.rom_cs   = rom_cs;
    assign bus.din      = din_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.underrun = underrun_q;

endmodule
